pixel_frame_readout: RTL and testbench

Parametrised frame sequencer and readout engine for the pixel array: drives erase, expose and single-slope conversion phases, latches one ramp code per pixel from the column comparators, then streams the frame out over the `read_data`/`data_ready`/`data_out_valid` handshake. It generalises the fixed 8-bit readout top in three ways: configurable pixel count and sample width, back-pressure mid-frame, and a free-running continuous-frame mode. It sits between the analog pixel array (comparator outputs, control strobes, ramp DAC code) and the downstream frame consumer.

---
 rtl/pixel_readout_pkg.sv | 17 +
 rtl/pixel_frame_readout_if.sv | 27 ++
 rtl/pixel_adc_latch.sv | 43 ++++
 rtl/pixel_frame_readout.sv | 133 +++++++++++++
 tb/tb_pixel_frame_readout.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel frame readout: sequencer state encoding and
// the pixel-index width helper.
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READOUT
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_frame_readout_if.sv
// Readout stream handshake between the frame engine (master) and the
// downstream frame consumer (slave).
interface pixel_frame_readout_if #(
    parameter int DATA_W = 8
) ();
    logic              read_data;
    logic              data_ready;
    logic              data_out_valid;
    logic [DATA_W-1:0] data_out;
    logic              frame_done;

    modport master (
        input  read_data,
        output data_ready,
        output data_out_valid,
        output data_out,
        output frame_done
    );

    modport slave (
        output read_data,
        input  data_ready,
        input  data_out_valid,
        input  data_out,
        input  frame_done
    );
endinterface

// File: rtl/pixel_adc_latch.sv
// Per-pixel single-slope capture: first comparator hit stores the ramp code,
// pixels still unlatched on the final code saturate to all-ones.
module pixel_adc_latch
    import pixel_readout_pkg::*;
#(
    parameter int NUM_PIXELS = 16,
    parameter int DATA_W     = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             conv_en,
    input  logic                             conv_last,
    input  logic [DATA_W-1:0]                ramp_code,
    input  logic [NUM_PIXELS-1:0]            cmp_in,
    input  logic [idx_w(NUM_PIXELS)-1:0]     rd_idx,
    output logic [DATA_W-1:0]                rd_data
);

    logic [NUM_PIXELS-1:0][DATA_W-1:0] mem;

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_px
        logic              hit_q;
        logic [DATA_W-1:0] sample_q;

        // Flags only live for one conversion; storing on conv_last doubles
        // as the saturation fill since the ramp sits at all-ones there.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                hit_q <= 1'b0;
            end else if (!conv_en) begin
                hit_q <= 1'b0;
            end else if (!hit_q && (cmp_in[i] || conv_last)) begin
                hit_q    <= 1'b1;
                sample_q <= ramp_code;
            end
        end

        assign mem[i] = sample_q;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pixel_frame_readout.sv
// Frame sequencer (erase/expose/convert/readout) with back-pressured pixel
// stream. Define PIXEL_TEST_PATTERN_EN to stream the pixel index instead of samples.
module pixel_frame_readout
    import pixel_readout_pkg::*;
#(
    parameter int NUM_PIXELS    = 16,
    parameter int DATA_W        = 8,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [NUM_PIXELS-1:0] cmp_in,
    output logic                  erase,
    output logic                  expose,
    output logic [DATA_W-1:0]     ramp_code,
    pixel_frame_readout_if.master rd
);

    localparam int IDX_W  = idx_w(NUM_PIXELS);
    localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  ERASE_LAST  = PH_W'(ERASE_CYCLES - 1);
    localparam logic [PH_W-1:0]  EXPOSE_LAST = PH_W'(EXPOSE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              erase_d, expose_d, ready_d, valid_d, done_d;
    logic [DATA_W-1:0] ramp_d, dout_d, sample, latch_data;
    logic              accept, conv_en, conv_last;

    assign accept    = (state_q == READOUT) && rd.read_data && rd.data_ready;
    assign conv_en   = (state_q == CONVERT);
    assign conv_last = conv_en && (ramp_code == '1);

    pixel_adc_latch #(
        .NUM_PIXELS (NUM_PIXELS),
        .DATA_W     (DATA_W)
    ) u_latch (
        .clk       (clk),
        .reset_n   (reset_n),
        .conv_en   (conv_en),
        .conv_last (conv_last),
        .ramp_code (ramp_code),
        .cmp_in    (cmp_in),
        .rd_idx    (idx_q),
        .rd_data   (latch_data)
    );

`ifdef PIXEL_TEST_PATTERN_EN
    assign sample = DATA_W'(idx_q);
`else
    assign sample = latch_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                phase_q <= '0;
            else if (state_q == ERASE || state_q == EXPOSE)
                phase_q <= phase_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                  state_d = ERASE;
            ERASE:   if (phase_q == ERASE_LAST)  state_d = EXPOSE;
            EXPOSE:  if (phase_q == EXPOSE_LAST) state_d = CONVERT;
            CONVERT: if (ramp_code == '1)        state_d = READOUT;
            // data_ready low in READOUT means every pixel has been accepted
            READOUT: if (!rd.data_ready)         state_d = continuous ? ERASE : IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Next-cycle values of every output, registered below.
    always_comb begin
        erase_d  = (state_d == ERASE);
        expose_d = (state_d == EXPOSE);
        ramp_d   = '0;
        if (state_d == CONVERT && state_q == CONVERT)
            ramp_d = ramp_code + 1'b1;

        valid_d = accept;
        dout_d  = accept ? sample : rd.data_out;
        idx_d   = idx_q;
        if (accept)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        ready_d = rd.data_ready;
        if (state_d != READOUT)
            ready_d = 1'b0;
        else if (state_q != READOUT)
            ready_d = 1'b1;
        else if (accept && idx_q == IDX_LAST)
            ready_d = 1'b0;

        done_d = (state_q == READOUT) && (state_d != READOUT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            erase             <= 1'b0;
            expose            <= 1'b0;
            ramp_code         <= '0;
            rd.data_ready     <= 1'b0;
            rd.data_out_valid <= 1'b0;
            rd.data_out       <= '0;
            rd.frame_done     <= 1'b0;
            idx_q             <= '0;
        end else begin
            erase             <= erase_d;
            expose            <= expose_d;
            ramp_code         <= ramp_d;
            rd.data_ready     <= ready_d;
            rd.data_out_valid <= valid_d;
            rd.data_out       <= dout_d;
            rd.frame_done     <= done_d;
            idx_q             <= idx_d;
        end
    end

endmodule

// File: tb/tb_pixel_frame_readout.sv
// Randomized frame-level bench for pixel_frame_readout against a cycle-count
// model of the phase timing and a queue-free accept/deliver readout model.
module tb_pixel_frame_readout;

    localparam int E    = 2;
    localparam int X    = 5;
    localparam int D    = 4;
`ifdef PIXEL_TEST_PATTERN_EN
    localparam int NP   = 20;
`else
    localparam int NP   = 4;
`endif
    localparam int NCODE = 1 << D;
    localparam int R     = 1 + E + X + NCODE;

    logic          clk = 1'b0;
    logic          reset_n, start, continuous;
    logic [NP-1:0] cmp_in;
    logic          erase, expose;
    logic [D-1:0]  ramp_code;

    pixel_frame_readout_if #(.DATA_W(D)) bus ();

    pixel_frame_readout #(
        .NUM_PIXELS    (NP),
        .DATA_W        (D),
        .ERASE_CYCLES  (E),
        .EXPOSE_CYCLES (X)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .continuous (continuous),
        .cmp_in     (cmp_in),
        .erase      (erase),
        .expose     (expose),
        .ramp_code  (ramp_code),
        .rd         (bus)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               failures = 0;
    logic [D-1:0]     last_out;
    logic [NCODE-1:0] wave [NP];
    logic [D-1:0]     exp_s [NP];

    // Random comparator waveform per pixel: a first rise at r (r=NCODE: never)
    // followed by random chatter that must be ignored.
    task automatic new_waves();
        for (int i = 0; i < NP; i++) begin
            int unsigned r;
            logic [NCODE-1:0] m;
            r = $urandom_range(0, NCODE);
            m = {NCODE{1'b1}} << r;
            wave[i] = NCODE'($urandom) & m;
            if (r < NCODE) wave[i][r] = 1'b1;
        end
    endtask

    // Drives one frame from IDLE (or from the first ERASE cycle when chained)
    // through its frame_done cycle, checking every cycle against the model.
    // mode: 0 read_data held high, 1 fixed toggle pattern, 2 random.
    task automatic run_frame(input bit cont, input int mode, input bit chained);
        logic [2+D-1:0] ctl_exp;
        logic [3+D:0]   bus_exp;
        int  acc, k;
        bit  pend, fin, rdv, dn, done_ok;
        bit  pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < NP; i++) begin
`ifdef PIXEL_TEST_PATTERN_EN
            exp_s[i] = D'(i % NCODE);
`else
            exp_s[i] = D'(NCODE - 1);
            for (int b = NCODE - 1; b >= 0; b--)
                if (wave[i][b]) exp_s[i] = D'(b);
`endif
        end
        continuous = cont;
        if (!chained) begin
            start = 1'b1;
            @(negedge clk);
        end
        for (int c = 1; c < R; c++) begin
            k = c - E - X - 1;
            ctl_exp = {c <= E, c > E && c <= E + X, (k >= 0) ? D'(k) : D'(0)};
            bus_exp = {1'b0, 1'b0, last_out, chained && c == 1};
            checks++;
            if ({erase, expose, ramp_code} !== ctl_exp) begin
                failures++;
                $display("FAIL phase c=%0d got=%b exp=%b", c, {erase, expose, ramp_code}, ctl_exp);
            end
            checks++;
            if ({bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done} !== bus_exp) begin
                failures++;
                $display("FAIL bus_idle c=%0d got=%b exp=%b", c,
                         {bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done}, bus_exp);
            end
            for (int i = 0; i < NP; i++)
                cmp_in[i] = (k >= 0) ? wave[i][k] : 1'($urandom);
            start          = 1'($urandom);
            bus.read_data  = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        acc = 0; pend = 0; fin = 0; done_ok = 0;
        for (int j = 0; j < 300; j++) begin
            dn = fin;
            ctl_exp = {dn && cont, 1'b0, D'(0)};
            bus_exp = {acc < NP, pend, last_out, dn};
            checks++;
            if ({erase, expose, ramp_code} !== ctl_exp) begin
                failures++;
                $display("FAIL readout_phase j=%0d got=%b exp=%b", j, {erase, expose, ramp_code}, ctl_exp);
            end
            checks++;
            if ({bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done} !== bus_exp) begin
                failures++;
                $display("FAIL readout j=%0d got=%b exp=%b", j,
                         {bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done}, bus_exp);
            end
            if (dn) begin
                done_ok = 1;
                break;
            end
            case (mode)
                0:       rdv = 1'b1;
                1:       rdv = (j < 7) ? pat[j] : 1'b1;
                default: rdv = 1'($urandom);
            endcase
            bus.read_data = rdv;
            cmp_in = NP'($urandom);
            fin = pend && (acc == NP);
            if (rdv && acc < NP) begin
                last_out = exp_s[acc];
                acc++;
                pend = 1;
            end else begin
                pend = 0;
            end
            @(negedge clk);
        end
        checks++;
        if (!done_ok) begin
            failures++;
            $display("FAIL frame_timeout got=no_frame_done exp=frame_done");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1;
        continuous = 1'b1;
        bus.read_data = 1'b1;
        cmp_in = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({erase, expose, ramp_code, bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done} !== '0) begin
            failures++;
            $display("FAIL reset got=%b exp=0", {erase, expose, ramp_code, bus.data_ready,
                     bus.data_out_valid, bus.data_out, bus.frame_done});
        end
        reset_n = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        last_out = '0;
        @(negedge clk);
        checks++;
        if ({erase, bus.data_ready, bus.frame_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {erase, bus.data_ready, bus.frame_done});
        end
    endtask

    task automatic test_basic_frame();
        new_waves();
        wave[0] = 16'hFFF8;
        wave[1] = 16'hFFFF;
        wave[2] = 16'h8000;
        wave[3] = 16'h0000;
        run_frame(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({erase, bus.data_ready, bus.data_out_valid, bus.frame_done} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_after i=%0d got=%b exp=0000", i,
                         {erase, bus.data_ready, bus.data_out_valid, bus.frame_done});
            end
        end
    endtask

    task automatic test_first_hit();
        new_waves();
        wave[1] = 16'hFE04;
        run_frame(1'b0, 2, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        new_waves();
        run_frame(1'b0, 1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        new_waves();
        run_frame(1'b0, 0, 1'b0);
        new_waves();
        run_frame(1'b0, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_continuous();
        new_waves();
        run_frame(1'b1, 2, 1'b0);
        new_waves();
        run_frame(1'b0, 2, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_convert();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < E + X + 6; c++) begin
            cmp_in = NP'($urandom);
            @(negedge clk);
        end
        checks++;
        if (ramp_code !== D'(5)) begin
            failures++;
            $display("FAIL ramp_before_reset got=%0d exp=5", ramp_code);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({erase, expose, ramp_code, bus.data_ready, bus.data_out_valid, bus.data_out, bus.frame_done} !== '0) begin
            failures++;
            $display("FAIL reset_convert got=%b exp=0", {erase, expose, ramp_code, bus.data_ready,
                     bus.data_out_valid, bus.data_out, bus.frame_done});
        end
        reset_n = 1'b1;
        last_out = '0;
        for (int i = 0; i < NCODE + 4; i++) begin
            @(negedge clk);
            checks++;
            if ({erase, ramp_code, bus.data_ready, bus.frame_done} !== '0) begin
                failures++;
                $display("FAIL post_reset i=%0d got=%b exp=0", i,
                         {erase, ramp_code, bus.data_ready, bus.frame_done});
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            new_waves();
            run_frame(1'b0, 2, 1'b0);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        cmp_in = '0;
        bus.read_data = 1'b0;
        last_out = '0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_first_hit();
        test_backpressure();
        test_back_to_back();
        test_continuous();
        test_reset_convert();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
